ddr_rx_sequencer: RTL

- Controller that sequences the HDR-DDR RX deserializer through a complete target-to-controller read.
- Steps the RX mode: ACK preamble, then per word {data byte hi, data byte lo, parity, preamble}, then on end-of-data {token, CRC}.
- Assembles 16-bit words from RX byte output, counts words, reports termination status to the DDR CCC engine.
- Sits between the DDR CCC FSM (request/status) and RX (o_rx_en/o_rx_mode out, mode_done/pre/error/data in).

---
 rtl/ddr_rx_sequencer_pkg.sv | 40 ++++
 rtl/ddr_rx_word_assembler.sv | 56 +++++
 rtl/ddr_rx_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ddr_rx_sequencer_pkg.sv
// Shared HDR-DDR RX sequencing constants: RX mode codes, sequencer states, termination codes.
// Reused by the RX deserializer and the DDR CCC FSM.
package ddr_rx_sequencer_pkg;

  localparam int unsigned RX_MODE_W = 4;
  localparam int unsigned ERR_W     = 3;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 16;

  typedef enum logic [RX_MODE_W-1:0] {
    RX_MODE_PREAMBLE   = 4'b0000,
    RX_MODE_DESER_BYTE = 4'b0011,
    RX_MODE_TOKEN      = 4'b0101,
    RX_MODE_PARITY     = 4'b0110,
    RX_MODE_CRC        = 4'b0111
  } rx_mode_e;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ACK     = 4'd1,
    ST_BYTE_HI = 4'd2,
    ST_BYTE_LO = 4'd3,
    ST_PARITY  = 4'd4,
    ST_PRE     = 4'd5,
    ST_TOKEN   = 4'd6,
    ST_CRC     = 4'd7,
    ST_FINISH  = 4'd8
  } seq_state_e;

  typedef enum logic [ERR_W-1:0] {
    ERR_OK       = 3'd0,
    ERR_NACK     = 3'd1,
    ERR_PARITY   = 3'd2,
    ERR_CRC      = 3'd3,
    ERR_OVERFLOW = 3'd4,
    ERR_TIMEOUT  = 3'd5,
    ERR_ABORT    = 3'd6
  } seq_err_e;

endpackage

// File: rtl/ddr_rx_word_assembler.sv
// Builds 16-bit words from RX bytes (hi first), pulses valid on commit and
// keeps a saturating count of committed words.
module ddr_rx_word_assembler
  import ddr_rx_sequencer_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              hi_en_i,
  input  logic              lo_en_i,
  input  logic              commit_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic [WORD_W-1:0] word_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [BYTE_W-1:0] hi_q;
  logic [BYTE_W-1:0] lo_q;
  logic [WORD_W-1:0] word_q;
  logic              valid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cnt_full_c;

  assign cnt_full_c = (cnt_q == CNT_W'(MAX_WORDS));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q    <= '0;
      lo_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      if (hi_en_i) hi_q <= data_i;
      if (lo_en_i) lo_q <= data_i;
      if (clr_i) begin
        cnt_q <= '0;
      end else if (commit_i) begin
        word_q  <= {hi_q, lo_q};
        valid_q <= 1'b1;
        // Saturate rather than wrap; the sequencer flags overflow at this bound.
        if (!cnt_full_c) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign word_o  = word_q;
  assign valid_o = valid_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/ddr_rx_sequencer.sv
// Steps the HDR-DDR RX deserializer through a target-to-controller read and reports status.
// Optional per-mode watchdog enabled by defining RX_SEQ_TIMEOUT_EN.
module ddr_rx_sequencer
  import ddr_rx_sequencer_pkg::*;
#(
  parameter int unsigned MAX_WORDS      = 16,
  parameter int unsigned CNT_W          = 5,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic                 i_rx_mode_done,
  input  logic                 i_rx_pre,
  input  logic                 i_rx_error,
  input  logic [BYTE_W-1:0]    i_rx_data,
  output logic                 o_rx_en,
  output logic [RX_MODE_W-1:0] o_rx_mode,
  output logic [WORD_W-1:0]    o_word_data,
  output logic                 o_word_valid,
  output logic [CNT_W-1:0]     o_word_count,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [ERR_W-1:0]     o_err_code
);

  seq_state_e state_q;
  rx_mode_e   rx_mode_q;
  logic       rx_en_q;
  logic       busy_q;
  logic       done_q;
  seq_err_e   err_q;

  logic       active_c;
  logic       mode_done_c;
  logic       tmo_hit_c;
  logic       fin_c;
  seq_err_e   fin_code_c;
  logic       hi_en_c;
  logic       lo_en_c;
  logic       commit_c;
  logic       clr_c;
  logic [CNT_W-1:0] word_count;

  assign active_c    = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  // Abort wins over a coincident mode_done, so the RX result is dropped.
  assign mode_done_c = active_c && i_rx_mode_done && !i_abort;
  assign clr_c       = (state_q == ST_IDLE) && i_start;
  assign hi_en_c     = mode_done_c && (state_q == ST_BYTE_HI);
  assign lo_en_c     = mode_done_c && (state_q == ST_BYTE_LO);
  assign commit_c    = mode_done_c && (state_q == ST_PARITY) && !i_rx_error;

`ifdef RX_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;

  // Watchdog restarts on every state change and only runs while RX is engaged.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      tmo_q <= '0;
    end else if (!active_c || i_rx_mode_done || i_abort) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  assign tmo_hit_c = active_c && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit_c = 1'b0;
`endif

  // Termination decode: abort, then RX result, then watchdog.
  always_comb begin
    fin_c      = 1'b0;
    fin_code_c = ERR_OK;
    if (active_c) begin
      if (i_abort) begin
        fin_c      = 1'b1;
        fin_code_c = ERR_ABORT;
      end else if (i_rx_mode_done) begin
        case (state_q)
          ST_ACK: if (i_rx_pre) begin
            fin_c      = 1'b1;
            fin_code_c = ERR_NACK;
          end
          ST_PARITY: if (i_rx_error) begin
            fin_c      = 1'b1;
            fin_code_c = ERR_PARITY;
          end
          ST_PRE: if (i_rx_pre && (word_count == CNT_W'(MAX_WORDS))) begin
            fin_c      = 1'b1;
            fin_code_c = ERR_OVERFLOW;
          end
          ST_TOKEN: if (i_rx_error) begin
            fin_c      = 1'b1;
            fin_code_c = ERR_CRC;
          end
          ST_CRC: begin
            fin_c      = 1'b1;
            fin_code_c = i_rx_error ? ERR_CRC : ERR_OK;
          end
          default: ;
        endcase
      end else if (tmo_hit_c) begin
        fin_c      = 1'b1;
        fin_code_c = ERR_TIMEOUT;
      end
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q   <= ST_IDLE;
      rx_mode_q <= RX_MODE_PREAMBLE;
      rx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= ERR_OK;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (i_start) begin
          state_q   <= ST_ACK;
          rx_mode_q <= RX_MODE_PREAMBLE;
          rx_en_q   <= 1'b1;
          busy_q    <= 1'b1;
          err_q     <= ERR_OK;
        end
        ST_FINISH: state_q <= ST_IDLE;
        default: begin
          if (fin_c) begin
            state_q   <= ST_FINISH;
            rx_mode_q <= RX_MODE_PREAMBLE;
            rx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= fin_code_c;
          end else if (mode_done_c) begin
            case (state_q)
              ST_ACK: begin
                state_q   <= ST_BYTE_HI;
                rx_mode_q <= RX_MODE_DESER_BYTE;
              end
              ST_BYTE_HI: state_q <= ST_BYTE_LO;
              ST_BYTE_LO: begin
                state_q   <= ST_PARITY;
                rx_mode_q <= RX_MODE_PARITY;
              end
              ST_PARITY: begin
                state_q   <= ST_PRE;
                rx_mode_q <= RX_MODE_PREAMBLE;
              end
              ST_PRE: begin
                if (i_rx_pre) begin
                  state_q   <= ST_BYTE_HI;
                  rx_mode_q <= RX_MODE_DESER_BYTE;
                end else begin
                  state_q   <= ST_TOKEN;
                  rx_mode_q <= RX_MODE_TOKEN;
                end
              end
              ST_TOKEN: begin
                state_q   <= ST_CRC;
                rx_mode_q <= RX_MODE_CRC;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  ddr_rx_word_assembler #(
    .MAX_WORDS (MAX_WORDS),
    .CNT_W     (CNT_W)
  ) u_word_asm (
    .clk_i    (i_sys_clk),
    .rst_i    (i_sys_rst),
    .clr_i    (clr_c),
    .hi_en_i  (hi_en_c),
    .lo_en_i  (lo_en_c),
    .commit_i (commit_c),
    .data_i   (i_rx_data),
    .word_o   (o_word_data),
    .valid_o  (o_word_valid),
    .count_o  (word_count)
  );

  assign o_word_count = word_count;
  assign o_rx_en      = rx_en_q;
  assign o_rx_mode    = rx_mode_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err_code   = err_q;

endmodule
